// File: rtl/stream_to_vector_pkg.sv
// Shared definitions for the sorter datapath: the collector/presenter state
// encoding and the pad value that makes filler elements sort to the top slots.
// Latency: n/a (package). Backpressure: n/a (package).
//
// Contents:
//   sm_state_t : SM_FILL (accepting elements) / SM_HOLD (presenting vector)
//   pad_value  : all-ones of a given element width (up to PAD_MAX_WIDTH bits)
package stream_to_vector_pkg;

  typedef enum logic {
    SM_FILL = 1'b0,
    SM_HOLD = 1'b1
  } sm_state_t;

  localparam int PAD_MAX_WIDTH = 64;

  // Callers truncate the result to their own element width.
  function automatic logic [PAD_MAX_WIDTH-1:0] pad_value(input int width);
    pad_value = {PAD_MAX_WIDTH{1'b1}} >> (PAD_MAX_WIDTH - width);
  endfunction

endpackage

// File: rtl/stream_to_vector.sv
// Collects a serial element stream into one NUM_ELEMS-wide vector for the sorter.
// Latency: dest_tvalid rises the cycle after the closing element's handshake.
// Backpressure: src_tready drops while a vector is held; the vector stays stable until dest_tready.
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   src_tvalid/src_tready         element handshake
//   src_tdata, src_tlast          element and end-of-frame marker
//   dest_tvalid/dest_tready       vector handshake
//   dest_tdata_raw                slot k at bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
//   dest_tcount                   real (non-pad) element count, only when
//                                 STREAM_TO_VECTOR_COUNT_EN is defined
//
// Frames close on src_tlast or after NUM_ELEMS elements; unwritten slots stay
// all-ones so padding sorts to the top. DATA_WIDTH is limited to PAD_MAX_WIDTH.
module stream_to_vector
  import stream_to_vector_pkg::*;
#(
  parameter int NUM_ELEMS  = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            src_tvalid,
  output logic                            src_tready,
  input  logic [DATA_WIDTH-1:0]           src_tdata,
  input  logic                            src_tlast,
  output logic                            dest_tvalid,
  input  logic                            dest_tready,
  output logic [DATA_WIDTH*NUM_ELEMS-1:0] dest_tdata_raw
`ifdef STREAM_TO_VECTOR_COUNT_EN
  ,
  output logic [$clog2(NUM_ELEMS+1)-1:0]  dest_tcount
`endif
);

  localparam int CNT_W = $clog2(NUM_ELEMS + 1);
  localparam logic [DATA_WIDTH-1:0] PAD = DATA_WIDTH'(pad_value(DATA_WIDTH));
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ELEMS - 1);

  sm_state_t             state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] slot_q [NUM_ELEMS];

  logic src_acc;
  logic dest_acc;

  // Handshake outputs follow the state register directly and are masked by
  // rst so nothing is offered or taken during the reset cycle.
  assign src_tready  = (state == SM_FILL) && !rst;
  assign dest_tvalid = (state == SM_HOLD) && !rst;

  assign src_acc  = src_tvalid && src_tready;
  assign dest_acc = dest_tvalid && dest_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SM_FILL;
      cnt   <= '0;
      for (int k = 0; k < NUM_ELEMS; k++) begin
        slot_q[k] <= PAD;
      end
    end else begin
      case (state)
        SM_FILL: begin
          if (src_acc) begin
            // Decoded write keeps the index the same width as the slot range.
            for (int k = 0; k < NUM_ELEMS; k++) begin
              if (cnt == CNT_W'(k)) begin
                slot_q[k] <= src_tdata;
              end
            end
            cnt <= cnt + 1'b1;
            if ((cnt == LAST_IDX) || src_tlast) begin
              state <= SM_HOLD;
            end
          end
        end
        SM_HOLD: begin
          // Re-pad on release so the next short frame starts clean.
          if (dest_acc) begin
            state <= SM_FILL;
            cnt   <= '0;
            for (int k = 0; k < NUM_ELEMS; k++) begin
              slot_q[k] <= PAD;
            end
          end
        end
        default: begin
          state <= SM_FILL;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_ELEMS; k++) begin : g_pack
    assign dest_tdata_raw[k*DATA_WIDTH +: DATA_WIDTH] = slot_q[k];
  end

`ifdef STREAM_TO_VECTOR_COUNT_EN
  // cnt is frozen in SM_HOLD, so it already equals the real element count.
  assign dest_tcount = cnt;
`endif

endmodule

// File: tb/tb_stream_to_vector.sv
// Randomized and directed stimulus for stream_to_vector with a queue-based
// scoreboard: a frame model pushes expected vectors, a monitor pops and checks.
module tb_stream_to_vector;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int VW = N * W;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          src_tvalid;
  logic          src_tready;
  logic [W-1:0]  src_tdata;
  logic          src_tlast;
  logic          dest_tvalid;
  logic          dest_tready;
  logic [VW-1:0] dest_tdata_raw;
`ifdef STREAM_TO_VECTOR_COUNT_EN
  logic [CW-1:0] dest_tcount;
`endif

  stream_to_vector #(.NUM_ELEMS(N), .DATA_WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .src_tvalid     (src_tvalid),
    .src_tready     (src_tready),
    .src_tdata      (src_tdata),
    .src_tlast      (src_tlast),
    .dest_tvalid    (dest_tvalid),
    .dest_tready    (dest_tready),
    .dest_tdata_raw (dest_tdata_raw)
`ifdef STREAM_TO_VECTOR_COUNT_EN
    ,
    .dest_tcount    (dest_tcount)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int nvec  = 0;
  int nfail = 0;

  typedef struct {
    logic [VW-1:0] vec;
    int            cnt;
    int            close_cyc;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] cur[$];

  int rdy_block = 0;
  bit rdy_rand  = 1'b0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Frame model: a frame is the elements since the last close; it closes on
  // tlast or on reaching N elements, and the vector is padded with 0xFF.
  function automatic void model_accept(input logic [W-1:0] d, input logic l);
    cur.push_back(d);
    if (cur.size() == N || l) begin
      exp_t e;
      e.vec = {VW{1'b1}};
      foreach (cur[k]) e.vec[k*W +: W] = cur[k];
      e.cnt       = cur.size();
      e.close_cyc = cyc;
      exp_q.push_back(e);
      cur.delete();
    end
  endfunction

  // Called right after a negedge; returns right after the negedge that
  // follows the accepting posedge.
  task automatic send(input logic [W-1:0] d, input logic l);
    int guard = 0;
    src_tvalid = 1'b1;
    src_tdata  = d;
    src_tlast  = l;
    while (src_tready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      nvec++;
      nfail++;
      $display("FAIL src_accept_timeout: element %h not accepted within 200 cycles", d);
    end else begin
      model_accept(d, l);
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    src_tvalid = 1'b0;
    src_tlast  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain();
    int guard = 0;
    idle(1);
    while ((exp_q.size() != 0 || dest_tvalid) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      nvec++;
      nfail++;
      $display("FAIL drain_timeout: %0d vectors still expected", exp_q.size());
    end
  endtask

  // Monitor / scoreboard
  logic          prev_vld = 1'b0;
  logic          prev_hs  = 1'b0;
  logic [VW-1:0] prev_vec = '0;

  initial begin
    dest_tready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_vld    = 1'b0;
        prev_hs     = 1'b0;
        dest_tready = 1'b0;
      end else begin
        if (rdy_block > 0) begin
          dest_tready = 1'b0;
          if (dest_tvalid) rdy_block--;
        end else begin
          dest_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (dest_tvalid) begin
          chk("hold_src_tready", VW'(src_tready), VW'(0));
          if (prev_vld && !prev_hs) chk("hold_stable", dest_tdata_raw, prev_vec);
          if (exp_q.size() == 0) begin
            nvec++;
            nfail++;
            $display("FAIL spurious_dest_tvalid: got vector %h, expected none", dest_tdata_raw);
          end else begin
            if (!prev_vld) chk("latency", VW'(cyc), VW'(exp_q[0].close_cyc + 1));
            if (dest_tready) begin
              chk("vector", dest_tdata_raw, exp_q[0].vec);
`ifdef STREAM_TO_VECTOR_COUNT_EN
              chk("tcount", VW'(dest_tcount), VW'(exp_q[0].cnt));
`endif
              void'(exp_q.pop_front());
            end
          end
        end
        prev_vld = dest_tvalid;
        prev_hs  = dest_tvalid && dest_tready;
        prev_vec = dest_tdata_raw;
      end
    end
  end

  initial begin
    rst        = 1'b1;
    src_tvalid = 1'b0;
    src_tdata  = '0;
    src_tlast  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_src_tready", VW'(src_tready), VW'(0));
    chk("rst_dest_tvalid", VW'(dest_tvalid), VW'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_src_tready", VW'(src_tready), VW'(1));
    chk("idle_dest_tvalid", VW'(dest_tvalid), VW'(0));
    chk("idle_pad", dest_tdata_raw, {VW{1'b1}});
`ifdef STREAM_TO_VECTOR_COUNT_EN
    chk("idle_tcount", VW'(dest_tcount), VW'(0));
`endif

    // Full frame, tlast on the 16th element
    for (int i = 0; i < N; i++) send(W'(8'h10 + i), i == N - 1);
    wait_drain();

    // Short frame
    send(8'h05, 1'b0);
    send(8'h03, 1'b0);
    send(8'h07, 1'b1);
    wait_drain();

    // tlast on first element
    send(8'h00, 1'b1);
    wait_drain();

    // Backpressure: vector held 5 cycles while the next frame waits upstream
    rdy_block = 5;
    for (int i = 0; i < N; i++) send(W'(8'h20 + i), i == N - 1);
    send(8'h40, 1'b0);
    send(8'h41, 1'b1);
    wait_drain();

    // No tlast: 20 elements, the second frame stays open
    for (int i = 0; i < 20; i++) send(W'(i), 1'b0);
    idle(10);
    chk("open_frame_no_valid", VW'(dest_tvalid), VW'(0));
    chk("open_frame_src_tready", VW'(src_tready), VW'(1));
    send(8'd20, 1'b1);
    wait_drain();

    // Reset mid-frame
    for (int i = 0; i < 6; i++) send(W'(8'h60 + i), 1'b0);
    idle(0);
    rst = 1'b1;
    cur.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_pad", dest_tdata_raw, {VW{1'b1}});
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    wait_drain();

    // Randomized frames with random gaps and random downstream readiness
    rdy_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        send(W'($urandom), (i == len - 1) && ($urandom_range(0, 3) != 0));
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
    end
    send(8'hEE, 1'b1);
    wait_drain();
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
